// File: rtl/vend_pkg.sv
// vend_pkg: shared types and constants for the customer-side sales controller.
//   - vend_state_e : sales FSM states
//   - PRICE_TABLE  : fixed product prices, 8 bits per type, type0 in the low byte
//   - price_of()   : price lookup by product type
//   - coin_value() : coin code to unit value (0=1, 1=2, 2=5, 3=10)
package vend_pkg;

    localparam int unsigned TYPE_W = 2;
    localparam int unsigned COIN_W = 2;

    typedef enum logic [1:0] {
        StIdle,
        StPay,
        StDispense,
        StChange
    } vend_state_e;

    localparam logic [31:0] PRICE_TABLE = {8'd15, 8'd12, 8'd8, 8'd5};

    function automatic logic [7:0] price_of(input logic [TYPE_W-1:0] t);
        return PRICE_TABLE[{t, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] coin_value(input logic [COIN_W-1:0] c);
        logic [7:0] v;
        case (c)
            2'd0:    v = 8'd1;
            2'd1:    v = 8'd2;
            2'd2:    v = 8'd5;
            default: v = 8'd10;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vend_dispense_if.sv
// vend_dispense_if: front-panel / charge-path / actuator bundle of vend_dispense.
//   slave  modport : the controller (inputs chg_*, sel_*, coin_*, cancel, stock_rd_type)
//   master modport : the environment driving commands and observing actuator pulses
interface vend_dispense_if
    import vend_pkg::*;
#(
    parameter int unsigned COUNT_W = 5,
    parameter int unsigned PRICE_W = 8
);
    logic                chg_valid;
    logic [TYPE_W-1:0]   chg_type;
    logic [COUNT_W-1:0]  chg_num;
    logic                sel_valid;
    logic [TYPE_W-1:0]   sel_type;
    logic                coin_valid;
    logic [COIN_W-1:0]   coin_val;
    logic                cancel;
    logic [TYPE_W-1:0]   stock_rd_type;
    logic [COUNT_W-1:0]  stock_rd_cnt;
    logic                busy;
    logic                sold_out;
    logic                coin_reject;
    logic                dispense;
    logic [TYPE_W-1:0]   dispense_type;
    logic                change_valid;
    logic [PRICE_W-1:0]  change_amt;

    modport slave (
        input  chg_valid, chg_type, chg_num, sel_valid, sel_type, coin_valid, coin_val,
        input  cancel, stock_rd_type,
        output stock_rd_cnt, busy, sold_out, coin_reject, dispense, dispense_type,
        output change_valid, change_amt
    );

    modport master (
        output chg_valid, chg_type, chg_num, sel_valid, sel_type, coin_valid, coin_val,
        output cancel, stock_rd_type,
        input  stock_rd_cnt, busy, sold_out, coin_reject, dispense, dispense_type,
        input  change_valid, change_amt
    );

endinterface

// File: rtl/vend_stock_table.sv
// vend_stock_table: per-type saturating stock counters.
//   i_add_*   : restock command, adds i_add_num to one type
//   i_dec_*   : removes one item of one type
//   i_rd_a/b  : two combinational readout ports (panel readout, selection check)
// Add and decrement on the same type in one cycle both apply; result clamps to [0, max].
module vend_stock_table
    import vend_pkg::*;
#(
    parameter int unsigned NUM_TYPES = 4,
    parameter int unsigned COUNT_W   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_add_valid,
    input  logic [TYPE_W-1:0]  i_add_type,
    input  logic [COUNT_W-1:0] i_add_num,
    input  logic               i_dec_valid,
    input  logic [TYPE_W-1:0]  i_dec_type,
    input  logic [TYPE_W-1:0]  i_rd_a_type,
    output logic [COUNT_W-1:0] o_rd_a_cnt,
    input  logic [TYPE_W-1:0]  i_rd_b_type,
    output logic [COUNT_W-1:0] o_rd_b_cnt
);
    localparam logic [COUNT_W:0] CntMax = {1'b0, {COUNT_W{1'b1}}};

    logic [COUNT_W-1:0] r_stock      [NUM_TYPES];
    logic [COUNT_W-1:0] w_stock_next [NUM_TYPES];

    for (genvar g = 0; g < NUM_TYPES; g++) begin : g_cnt
        logic             w_add_hit;
        logic             w_dec_hit;
        logic [COUNT_W:0] w_sum;
        logic [COUNT_W:0] w_net;

        assign w_add_hit = i_add_valid && (i_add_type == TYPE_W'(g));
        assign w_dec_hit = i_dec_valid && (i_dec_type == TYPE_W'(g));
        // One extra bit holds the unclamped sum before saturation.
        assign w_sum = {1'b0, r_stock[g]} + (w_add_hit ? {1'b0, i_add_num} : '0);
        assign w_net = (w_dec_hit && (w_sum != '0)) ? w_sum - 1'b1 : w_sum;
        assign w_stock_next[g] = (w_net > CntMax) ? CntMax[COUNT_W-1:0] : w_net[COUNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TYPES; i++) r_stock[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_TYPES; i++) r_stock[i] <= w_stock_next[i];
        end
    end

    assign o_rd_a_cnt = r_stock[i_rd_a_type];
    assign o_rd_b_cnt = r_stock[i_rd_b_type];

endmodule

// File: rtl/vend_dispense.sv
// vend_dispense: customer-side sales controller.
//   clk, rst_n : system clock (rising edge), asynchronous active-low reset
//   bus        : vend_dispense_if.slave - restock, selection, coins, cancel, stock readout,
//                busy / sold_out / coin_reject / dispense / change actuator outputs
// Flow: IDLE -(select, in stock)-> PAY -(credit >= price)-> DISPENSE -> CHANGE -> IDLE.
// Optional macro VEND_TIMEOUT_EN: refund after TIMEOUT_CYC PAY cycles without a coin.
module vend_dispense
    import vend_pkg::*;
#(
    parameter int unsigned NUM_TYPES   = 4,
    parameter int unsigned COUNT_W     = 5,
    parameter int unsigned PRICE_W     = 8,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input logic             clk,
    input logic             rst_n,
    vend_dispense_if.slave  bus
);
    vend_state_e        r_state, w_state_next;
    logic [TYPE_W-1:0]  r_type, w_type_next;
    logic [PRICE_W-1:0] r_credit, w_credit_next;
    logic [PRICE_W-1:0] w_credit_coin;
    logic [PRICE_W-1:0] w_price;
    logic               r_sold_out, r_coin_reject;
    logic [COUNT_W-1:0] w_sel_stock;
    logic               w_dec;
    logic               w_timeout;

    assign w_price       = PRICE_W'(price_of(r_type));
    // Credit including a coin arriving this cycle (only meaningful in PAY).
    assign w_credit_coin = r_credit +
                           (bus.coin_valid ? PRICE_W'(coin_value(bus.coin_val)) : '0);
    assign w_dec         = (r_state == StDispense);

    vend_stock_table #(
        .NUM_TYPES (NUM_TYPES),
        .COUNT_W   (COUNT_W)
    ) u_stock (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_add_valid (bus.chg_valid),
        .i_add_type  (bus.chg_type),
        .i_add_num   (bus.chg_num),
        .i_dec_valid (w_dec),
        .i_dec_type  (r_type),
        .i_rd_a_type (bus.stock_rd_type),
        .o_rd_a_cnt  (bus.stock_rd_cnt),
        .i_rd_b_type (bus.sel_type),
        .o_rd_b_cnt  (w_sel_stock)
    );

`ifdef VEND_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TIMEOUT_CYC + 1);
    logic [ToW-1:0] r_to_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if ((r_state != StPay) || bus.coin_valid) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // r_to_cnt counts coinless PAY cycles already elapsed; this is the last one.
    assign w_timeout = (r_state == StPay) && !bus.coin_valid &&
                       (r_to_cnt == ToW'(TIMEOUT_CYC - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_next  = r_state;
        w_type_next   = r_type;
        w_credit_next = r_credit;
        case (r_state)
            StIdle: begin
                if (bus.sel_valid && (w_sel_stock != '0)) begin
                    w_type_next   = bus.sel_type;
                    w_credit_next = '0;
                    w_state_next  = StPay;
                end
            end
            StPay: begin
                w_credit_next = w_credit_coin;
                if (bus.cancel) begin
                    w_state_next = (w_credit_coin == '0) ? StIdle : StChange;
                end else if (bus.coin_valid && (w_credit_coin >= w_price)) begin
                    w_state_next = StDispense;
                end else if (w_timeout) begin
                    w_state_next = (r_credit == '0) ? StIdle : StChange;
                end
            end
            StDispense: begin
                // Credit register is reused to hold the change owed.
                w_credit_next = r_credit - w_price;
                w_state_next  = (r_credit != w_price) ? StChange : StIdle;
            end
            StChange: begin
                w_credit_next = '0;
                w_state_next  = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_type        <= '0;
            r_credit      <= '0;
            r_sold_out    <= 1'b0;
            r_coin_reject <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_type        <= w_type_next;
            r_credit      <= w_credit_next;
            r_sold_out    <= (r_state == StIdle) && bus.sel_valid && (w_sel_stock == '0);
            r_coin_reject <= bus.coin_valid && (r_state != StPay);
        end
    end

    assign bus.busy          = (r_state != StIdle);
    assign bus.sold_out      = r_sold_out;
    assign bus.coin_reject   = r_coin_reject;
    assign bus.dispense      = (r_state == StDispense);
    assign bus.dispense_type = (r_state == StDispense) ? r_type : '0;
    assign bus.change_valid  = (r_state == StChange);
    assign bus.change_amt    = (r_state == StChange) ? r_credit : '0;

endmodule

// File: tb/tb_vend_dispense.sv
// tb_vend_dispense: directed self-checking bench for vend_dispense.
// Inputs change #1 after a rising edge; outputs are sampled at the same point.
module tb_vend_dispense;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    vend_dispense_if #(.COUNT_W(5), .PRICE_W(8)) bus ();

    vend_dispense #(
        .NUM_TYPES   (4),
        .COUNT_W     (5),
        .PRICE_W     (8),
        .TIMEOUT_CYC (1000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.chg_valid  = 1'b0;
        bus.chg_type   = '0;
        bus.chg_num    = '0;
        bus.sel_valid  = 1'b0;
        bus.sel_type   = '0;
        bus.coin_valid = 1'b0;
        bus.coin_val   = '0;
        bus.cancel     = 1'b0;
    endtask

    task automatic restock(input logic [1:0] t, input logic [4:0] n);
        bus.chg_valid = 1'b1;
        bus.chg_type  = t;
        bus.chg_num   = n;
        tick();
        bus.chg_valid = 1'b0;
    endtask

    task automatic select(input logic [1:0] t);
        bus.sel_valid = 1'b1;
        bus.sel_type  = t;
        tick();
        bus.sel_valid = 1'b0;
    endtask

    task automatic coin(input logic [1:0] c);
        bus.coin_valid = 1'b1;
        bus.coin_val   = c;
        tick();
        bus.coin_valid = 1'b0;
    endtask

    initial begin
        int n;
        bit seen;
        clear_inputs();
        bus.stock_rd_type = 2'd0;

        // Reset state
        #2;
        check("rst_busy", bus.busy, 0);
        check("rst_dispense", bus.dispense, 0);
        check("rst_change_valid", bus.change_valid, 0);
        check("rst_stock", bus.stock_rd_cnt, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Sold out: type1 empty
        select(2'd1);
        check("t1_sold_out", bus.sold_out, 1);
        check("t1_busy", bus.busy, 0);
        check("t1_dispense", bus.dispense, 0);
        tick();
        check("t1_sold_out_pulse", bus.sold_out, 0);

        // Buy type2 (price 12) with 10+5, change 3
        restock(2'd2, 5'd15);
        bus.stock_rd_type = 2'd2;
        check("t2_stock_after_chg", bus.stock_rd_cnt, 15);
        select(2'd2);
        check("t2_busy", bus.busy, 1);
        coin(2'd3);
        check("t2_no_early_dispense", bus.dispense, 0);
        coin(2'd2);
        check("t2_dispense", bus.dispense, 1);
        check("t2_dispense_type", bus.dispense_type, 2);
        check("t2_coin_reject_pay", bus.coin_reject, 0);
        tick();
        check("t2_change_valid", bus.change_valid, 1);
        check("t2_change_amt", bus.change_amt, 3);
        check("t2_stock_dec", bus.stock_rd_cnt, 14);
        check("t2_dispense_pulse", bus.dispense, 0);
        tick();
        check("t2_idle", bus.busy, 0);
        check("t2_change_pulse", bus.change_valid, 0);

        // Cancel refunds 2, no dispense
        restock(2'd0, 5'd1);
        select(2'd0);
        coin(2'd1);
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        check("t3_change_valid", bus.change_valid, 1);
        check("t3_change_amt", bus.change_amt, 2);
        check("t3_no_dispense", bus.dispense, 0);
        tick();
        bus.stock_rd_type = 2'd0;
        check("t3_idle", bus.busy, 0);
        check("t3_stock", bus.stock_rd_cnt, 1);

        // Cancel with zero credit: straight to idle, no pulse
        select(2'd2);
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        check("t3b_idle", bus.busy, 0);
        check("t3b_no_change", bus.change_valid, 0);

        // Saturation and clamping on type3
        bus.stock_rd_type = 2'd3;
        restock(2'd3, 5'd31);
        restock(2'd3, 5'd31);
        check("t4_saturate", bus.stock_rd_cnt, 31);
        select(2'd3);
        coin(2'd3);
        coin(2'd2);
        check("t4_dispense", bus.dispense, 1);
        check("t4_dispense_type", bus.dispense_type, 3);
        restock(2'd3, 5'd4);
        check("t4_clamp", bus.stock_rd_cnt, 31);
        check("t4_exact_idle", bus.busy, 0);
        check("t4_no_change", bus.change_valid, 0);

        // Coin in IDLE rejected; selection during PAY ignored
        coin(2'd0);
        check("t5_coin_reject", bus.coin_reject, 1);
        check("t5_reject_busy", bus.busy, 0);
        tick();
        check("t5_reject_pulse", bus.coin_reject, 0);
        select(2'd0);
        select(2'd1);
        check("t5_still_pay", bus.busy, 1);
        coin(2'd2);
        check("t5_dispense", bus.dispense, 1);
        check("t5_dispense_type", bus.dispense_type, 0);
        tick();
        bus.stock_rd_type = 2'd0;
        check("t5_idle", bus.busy, 0);
        check("t5_stock0", bus.stock_rd_cnt, 0);
        select(2'd0);
        check("t5_sold_out_after_last", bus.sold_out, 1);

        // PAY inactivity on type3 with 5 credit
        select(2'd3);
        coin(2'd2);
`ifdef VEND_TIMEOUT_EN
        n = 0;
        seen = 1'b0;
        while (!seen && n < 1100) begin
            tick();
            n++;
            if (bus.change_valid) seen = 1'b1;
        end
        check("t6_timeout_seen", seen, 1);
        check("t6_timeout_cycles", n, 1000);
        check("t6_timeout_amt", bus.change_amt, 5);
        tick();
        check("t6_timeout_idle", bus.busy, 0);
`else
        n = 0;
        seen = 1'b0;
        repeat (2000) begin
            tick();
            n++;
            if (bus.change_valid || bus.dispense || !bus.busy) seen = 1'b1;
        end
        check("t6_still_pay", bus.busy, 1);
        check("t6_no_exit", seen, 0);
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        check("t6_cancel_amt", bus.change_amt, 5);
        tick();
        check("t6_idle", bus.busy, 0);
`endif

        // Reset mid-transaction discards credit
        select(2'd3);
        coin(2'd3);
        bus.stock_rd_type = 2'd3;
        rst_n = 1'b0;
        #1;
        check("t7_rst_busy", bus.busy, 0);
        check("t7_rst_stock", bus.stock_rd_cnt, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t7_no_change", bus.change_valid, 0);
        check("t7_no_dispense", bus.dispense, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
